// File: rtl/muldiv_pkg.sv
// Shared encodings, widths and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned ITER  = XLEN;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_RUN  = 2'b10,
        ST_FIX  = 2'b11
    } md_state_e;

    // Magnitude of x when treated as signed; pass-through for unsigned ops.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Accumulator / partial-remainder shift register: one shift-add or one
// restoring-divide step per cycle on unsigned magnitudes.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [DW-1:0]   acc
);

    logic [DW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] shreg_q, shreg_d;   // multiplier (LSB out) or dividend (MSB out)
    logic [XLEN-1:0] addend_q, addend_d; // multiplicand or divisor
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;
    logic            quo_bit;
    logic [XLEN-1:0] rem_next;

    // One iteration step and operand load
    always_comb begin
        mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + (shreg_q[0] ? {1'b0, addend_q} : '0);
        trial    = {acc_q[DW-1:XLEN], shreg_q[XLEN-1]};
        diff     = {1'b0, trial} - {2'b00, addend_q};
        quo_bit  = ~diff[XLEN+1];
        rem_next = quo_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];

        acc_d    = acc_q;
        shreg_d  = shreg_q;
        addend_d = addend_q;
        if (load) begin
            acc_d    = '0;
            shreg_d  = is_div ? a_mag : b_mag;
            addend_d = is_div ? b_mag : a_mag;
        end else if (step) begin
            if (is_div) begin
                acc_d   = {rem_next, acc_q[XLEN-2:0], quo_bit};
                shreg_d = {shreg_q[XLEN-2:0], 1'b0};
            end else begin
                acc_d   = {mul_sum, acc_q[XLEN-1:1]};
                shreg_d = {1'b0, shreg_q[XLEN-1:1]};
            end
        end
    end

    // Iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            shreg_q  <= '0;
            addend_q <= '0;
        end else begin
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            addend_q <= addend_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer owning Hi/Lo: latches operands, runs 32 iterations,
// applies sign fixup and stalls the core while busy.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        rd_req,
    input  logic        rd_hi,
    input  logic        wr_hi,
    input  logic        wr_lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        dz,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
    logic             neg_q, neg_d, rneg_q, rneg_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic             accept, load, step, fix;
    logic             is_div, is_signed, b_zero;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic [DW-1:0]    acc, prod;
    logic [XLEN-1:0]  quo, rem, res_hi, res_lo;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PREP;
            ST_PREP: state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM control decode
    always_comb begin
        accept = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        fix    = 1'b0;
        case (state_q)
            ST_IDLE: accept = start;
            ST_PREP: load   = 1'b1;
            ST_RUN:  step   = 1'b1;
            ST_FIX:  fix    = 1'b1;
            default: ;
        endcase
    end

    assign is_div    = (op_q == MD_DIVU) || (op_q == MD_DIV);
    assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign b_zero    = (b_q == '0);
    assign a_mag     = mag(a_q, is_signed);
    assign b_mag     = mag(b_q, is_signed);

    muldiv_iter u_iter (
        .clk    (clk),
        .rst_n  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    // Sign fixup; a zero divisor bypasses it with the architected fill values
    always_comb begin
        prod = neg_q  ? (~acc + DW'(1)) : acc;
        quo  = neg_q  ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
        rem  = rneg_q ? (~acc[DW-1:XLEN] + XLEN'(1)) : acc[DW-1:XLEN];
        if (is_div) begin
            res_hi = b_zero ? a_q : rem;
            res_lo = b_zero ? '1  : quo;
        end else begin
            res_hi = prod[DW-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end
    end

    // Datapath next-state: operand latch, signs, counter, Hi/Lo and status
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        cnt_d  = step ? (cnt_q + CNT_W'(1)) : '0;
        if (accept) begin
            op_d = md_op_e'(op);
            a_d  = srca;
            b_d  = srcb;
            dz_d = 1'b0;
        end
        if (load) begin
            neg_d  = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
            rneg_d = is_signed & a_q[XLEN-1];
        end
        if (fix) begin
            hi_d = res_hi;
            lo_d = res_lo;
            dz_d = is_div & b_zero;
        end
        // MTHI/MTLO only take effect in IDLE and lose to a simultaneous start
        if ((state_q == ST_IDLE) && !start) begin
            if (wr_hi) hi_d = srca;
            if (wr_lo) lo_d = srca;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = fix;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            op_q   <= MD_MULTU;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign dz      = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign stall   = busy_q & (start | rd_req | wr_hi | wr_lo);
    assign rd_data = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        rd_req;
    logic        rd_hi;
    logic        wr_hi;
    logic        wr_lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_chk = 0;
    int n_err = 0;

    muldiv_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .rd_req  (rd_req),
        .rd_hi   (rd_hi),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .dz      (dz),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic definitions
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        edz = 1'b0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (o)
            2'd0: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            2'd1: begin p = 64'(sa * sb);            eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
                end else if (o == 2'd2) begin
                    el = a / b; eh = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    el = 32'(q); eh = 32'(r);
                end
            end
        endcase
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; srca = a; srcb = b;
    endtask

    // Called in cycle 0 with start driven; returns in cycle 35
    task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el, input logic edz);
        int busy_cnt = 0;
        int done_cnt = 0;
        @(negedge clk);
        start = 1'b0; srca = $urandom; srcb = $urandom; op = 2'($urandom);
        check_eq({tag, "_dz_clr"}, 64'(dz), 64'(0));
        for (int c = 1; c <= 34; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(34));
        check_eq({tag, "_early_done"}, 64'(done_cnt), 64'(0));
        check_eq({tag, "_done"}, 64'(done), 64'(1));
        check_eq({tag, "_busy35"}, 64'(busy), 64'(0));
        check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
        check_eq({tag, "_lo"}, 64'(lo), 64'(el));
        check_eq({tag, "_dz"}, 64'(dz), 64'(edz));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz;
        model(o, a, b, eh, el, edz);
        @(negedge clk);
        issue(o, a, b);
        finish_op(tag, eh, el, edz);
    endtask

    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        logic [31:0] eh, el, eh2, el2;
        logic        edz, edz2;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          stall_bad, done_cnt;

        reset = 1'b0; start = 1'b0; op = 2'd0; srca = '0; srcb = '0;
        rd_req = 1'b0; rd_hi = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_dz", 64'(dz), 64'(0));
        check_eq("rst_stall", 64'(stall), 64'(0));
        check_eq("rst_hilo", {32'(hi), 32'(lo)}, 64'(0));
        reset = 1'b1;

        // Directed corner operations
        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", 2'd2, 32'd100, 32'd0);
        run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero", 2'd3, 32'hFFFF_FFF0, 32'd0);
        run_op("div_negrem", 2'd3, 32'd7, 32'hFFFF_FFFE);

        // rd_req stall window, ignored second start, back-to-back start at cycle 35
        model(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, edz);
        @(negedge clk);
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        rd_hi = 1'b1;
        stall_bad = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start  = 1'b0;
            rd_req = (c >= 5);
            if (c == 10) issue(2'd3, 32'h0000_0005, 32'h0000_0003);
            #1;
            if (stall !== (c >= 5)) stall_bad++;
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("stall_window", 64'(stall_bad), 64'(0));
        check_eq("stall_c35", 64'(stall), 64'(0));
        check_eq("rd_hi_c35", 64'(rd_data), 64'(eh));
        rd_hi = 1'b0;
        #1;
        check_eq("rd_lo_c35", 64'(rd_data), 64'(el));
        rd_req = 1'b0;
        model(2'd1, 32'h8000_0000, 32'h8000_0000, eh2, el2, edz2);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000);
        finish_op("b2b", eh2, el2, edz2);

        // MTHI/MTLO in IDLE, start beats MTHI, MTLO while busy stalls and is dropped
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; srca = 32'hA5A5_0001;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        check_eq("mthi", 64'(hi), 64'h0000_0000_A5A5_0001);
        check_eq("mtlo", 64'(lo), 64'h0000_0000_A5A5_0001);
        model(2'd0, 32'h10, 32'h20, eh, el, edz);
        issue(2'd0, 32'h10, 32'h20);
        wr_hi = 1'b1;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        check_eq("start_beats_mthi", 64'(hi), 64'h0000_0000_A5A5_0001);
        wr_lo = 1'b1; srca = 32'hDEAD;
        #1;
        check_eq("mtlo_busy_stall", 64'(stall), 64'(1));
        @(negedge clk);
        wr_lo = 1'b0;
        check_eq("mtlo_busy_drop", 64'(lo), 64'h0000_0000_A5A5_0001);
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check_eq("wr_op_done", 64'(done), 64'(1));
        check_eq("wr_op_res", {32'(hi), 32'(lo)}, {eh, el});

        // Randomized operations, biased towards corner operands
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 7) == 0) rb = rb >> $urandom_range(16, 31);
            run_op($sformatf("rnd%0d_op%0d", n, ro), ro, ra, rb);
        end

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        issue(2'd1, 32'hFFFF_FFFD, 32'd7);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_hilo", {32'(hi), 32'(lo)}, 64'(0));
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("midrst_no_done", 64'(done_cnt), 64'(0));
        check_eq("midrst_idle", 64'(busy), 64'(0));
        wr_lo = 1'b1; srca = 32'h1234;
        @(negedge clk);
        wr_lo = 1'b0;
        check_eq("post_rst_mtlo", 64'(lo), 64'h0000_0000_0000_1234);
        check_eq("post_rst_hi", 64'(hi), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
